// File: rtl/half_adder_pkg.sv
// Shared defaults and result type for the half-adder lane array.
package half_adder_pkg;

    localparam int DEFAULT_WIDTH      = 1;
    localparam int DEFAULT_REGISTERED = 1;

    typedef struct packed {
        logic sum;
        logic cout;
    } ha_result_t;

    function automatic ha_result_t haEval(input logic a, input logic b);
        ha_result_t res;
        res.sum  = a ^ b;
        res.cout = a & b;
        return res;
    endfunction

endpackage

// File: rtl/ha_cell.sv
// One-bit combinational half adder used as the per-lane leaf of half_adder.
module ha_cell
    import half_adder_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_cout
);

    ha_result_t w_res;

    assign w_res  = haEval(i_a, i_b);
    assign o_sum  = w_res.sum;
    assign o_cout = w_res.cout;

endmodule

// File: rtl/half_adder.sv
// Array of independent half-adder lanes with optional output registers and
// a valid flag that always carries one cycle of latency.
module half_adder
    import half_adder_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int REGISTERED = DEFAULT_REGISTERED
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] cout,
    output logic             out_valid
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_cout;
    logic             r_valid;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        ha_cell u_cell (
            .i_a    (a[i]),
            .i_b    (b[i]),
            .o_sum  (w_sum[i]),
            .o_cout (w_cout[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
        end
    end

    assign out_valid = r_valid;

    if (REGISTERED != 0) begin : g_reg
        logic [WIDTH-1:0] r_sum;
        logic [WIDTH-1:0] r_cout;

        // Results only update on a valid beat, so an idle cycle keeps the last answer visible.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sum  <= '0;
                r_cout <= '0;
            end else if (in_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_cout;
            end
        end

        assign sum  = r_sum;
        assign cout = r_cout;
    end else begin : g_comb
        assign sum  = w_sum;
        assign cout = w_cout;
    end

endmodule

// File: tb/tb_half_adder.sv
// Directed self-checking bench covering registered 1-lane, registered 4-lane
// and combinational 1-lane configurations of half_adder.
module tb_half_adder;

    logic clk;
    logic rst_n;

    logic       iv1, a1, b1, sum1, cout1, ov1;
    logic       iv4, ov4;
    logic [3:0] a4, b4, sum4, cout4;
    logic       ivc, ac, bc, sumc, coutc, ovc;

    int testsRun;
    int testsFailed;

    half_adder #(.WIDTH(1), .REGISTERED(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .a(a1), .b(b1),
        .sum(sum1), .cout(cout1), .out_valid(ov1)
    );

    half_adder #(.WIDTH(4), .REGISTERED(1)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .a(a4), .b(b4),
        .sum(sum4), .cout(cout4), .out_valid(ov4)
    );

    half_adder #(.WIDTH(1), .REGISTERED(0)) u_dutc (
        .clk(clk), .rst_n(rst_n), .in_valid(ivc), .a(ac), .b(bc),
        .sum(sumc), .cout(coutc), .out_valid(ovc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [3:0] expSum;
        logic [3:0] expCout;
        logic [1:0] ab;

        testsRun    = 0;
        testsFailed = 0;
        // Truth table indexed by {a,b}: sum = 0,1,1,0  cout = 0,0,0,1
        expSum  = 4'b0110;
        expCout = 4'b1000;

        // Reset held with live operands: registered outputs must read zero before any edge
        rst_n = 1'b0;
        iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        iv4 = 1'b1; a4 = 4'b1111; b4 = 4'b1111;
        ivc = 1'b1; ac = 1'b1; bc = 1'b0;
        #2;
        checkOutput("rst_sum1", {7'd0, sum1}, 8'h0);
        checkOutput("rst_cout1", {7'd0, cout1}, 8'h0);
        checkOutput("rst_ov1", {7'd0, ov1}, 8'h0);
        checkOutput("rst_sum4", {4'd0, sum4}, 8'h0);
        checkOutput("rst_ov4", {7'd0, ov4}, 8'h0);
        checkOutput("rst_comb_sum", {7'd0, sumc}, 8'h1);
        checkOutput("rst_comb_ov", {7'd0, ovc}, 8'h0);

        // Exhaustive walk on the registered single lane, one vector per cycle
        @(negedge clk);
        rst_n = 1'b1;
        iv4 = 1'b0; ivc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            iv1 = 1'b1;
            {a1, b1} = ab;
            @(negedge clk);
            checkOutput($sformatf("exh_sum_%0d", i), {7'd0, sum1}, {7'd0, expSum[ab]});
            checkOutput($sformatf("exh_cout_%0d", i), {7'd0, cout1}, {7'd0, expCout[ab]});
            checkOutput($sformatf("exh_ov_%0d", i), {7'd0, ov1}, 8'h1);
        end

        // Idle beat with new operands: previous 11 result must be retained
        iv1 = 1'b0; a1 = 1'b0; b1 = 1'b1;
        @(negedge clk);
        checkOutput("hold_sum", {7'd0, sum1}, 8'h0);
        checkOutput("hold_cout", {7'd0, cout1}, 8'h1);
        checkOutput("hold_ov", {7'd0, ov1}, 8'h0);

        // Multi-lane patterns: lanes must stay independent
        iv4 = 1'b1; a4 = 4'b1100; b4 = 4'b1010;
        @(negedge clk);
        checkOutput("ml_sum_a", {4'd0, sum4}, 8'h06);
        checkOutput("ml_cout_a", {4'd0, cout4}, 8'h08);
        checkOutput("ml_ov_a", {7'd0, ov4}, 8'h1);
        a4 = 4'b1111; b4 = 4'b0101;
        @(negedge clk);
        checkOutput("ml_sum_b", {4'd0, sum4}, 8'h0A);
        checkOutput("ml_cout_b", {4'd0, cout4}, 8'h05);
        iv4 = 1'b0; a4 = 4'b0000; b4 = 4'b0000;
        @(negedge clk);
        checkOutput("ml_hold_sum", {4'd0, sum4}, 8'h0A);
        checkOutput("ml_ov_idle", {7'd0, ov4}, 8'h0);

        // Mid-stream reset: 11 presented, reset lands before the capturing edge
        iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mrst_cout_now", {7'd0, cout1}, 8'h0);
        checkOutput("mrst_ov_now", {7'd0, ov1}, 8'h0);
        @(posedge clk);
        #1;
        checkOutput("mrst_cout_edge", {7'd0, cout1}, 8'h0);
        checkOutput("mrst_ov_edge", {7'd0, ov1}, 8'h0);
        checkOutput("mrst_sum4", {4'd0, sum4}, 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        a1 = 1'b1; b1 = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_sum", {7'd0, sum1}, 8'h1);
        checkOutput("post_rst_cout", {7'd0, cout1}, 8'h0);
        checkOutput("post_rst_ov", {7'd0, ov1}, 8'h1);

        // Combinational lane: results appear in the same timestep, valid lags a cycle
        checkOutput("comb_ov_idle", {7'd0, ovc}, 8'h0);
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            ivc = 1'b1;
            {ac, bc} = ab;
            #1;
            checkOutput($sformatf("comb_sum_%0d", i), {7'd0, sumc}, {7'd0, expSum[ab]});
            checkOutput($sformatf("comb_cout_%0d", i), {7'd0, coutc}, {7'd0, expCout[ab]});
            @(negedge clk);
            checkOutput($sformatf("comb_ov_%0d", i), {7'd0, ovc}, 8'h1);
        end
        ivc = 1'b0;
        #1;
        checkOutput("comb_ov_lag", {7'd0, ovc}, 8'h1);
        @(negedge clk);
        checkOutput("comb_ov_drop", {7'd0, ovc}, 8'h0);
        checkOutput("comb_sum_noval", {7'd0, sumc}, 8'h0);
        checkOutput("comb_cout_noval", {7'd0, coutc}, 8'h1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/half_adder.md
Name: half_adder

Overview:
- Registered single-stage half-adder array. Each lane computes sum = a XOR b and carry = a AND b on one bit pair.
- Default configuration is a single lane, for use as a leaf arithmetic cell and for exhaustive truth-table checks.
- Outputs are registered so the block drops into clocked datapaths with a fixed one-cycle latency.
- Optional pass-through mode exposes the purely combinational function.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (min 1).
- REGISTERED, 1, 1 = outputs registered (latency 1 cycle); 0 = combinational outputs, clock/reset affect only out_valid.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies a and b this cycle.
- a  input  WIDTH  operand A, one bit per lane.
- b  input  WIDTH  operand B, one bit per lane.
- sum  output  WIDTH  per-lane a XOR b.
- cout  output  WIDTH  per-lane a AND b (carry out).
- out_valid  output  1  sum/cout hold a freshly computed result.

Behaviour:
- Per-lane function, lane i independent:
  - sum[i] = a[i] ^ b[i]
  - cout[i] = a[i] & b[i]
  - No carry propagates between lanes.
- Truth table per lane (a,b -> sum,cout): 00->0,0; 01->1,0; 10->1,0; 11->0,1.
- Reset: rst_n low forces sum=0, cout=0, out_valid=0 immediately, without waiting for a clock edge. Release is sampled synchronously; first capture happens on the first rising clk edge with rst_n high.
- REGISTERED=1:
  - On a rising edge with in_valid=1: sum/cout register the function of a/b, and out_valid<=1.
  - On a rising edge with in_valid=0: sum/cout hold their previous values, and out_valid<=0.
  - Latency is exactly 1 cycle, with full throughput (a new operand pair every cycle).
- REGISTERED=0:
  - sum/cout are continuous combinational functions of a/b, independent of in_valid and reset.
  - out_valid = in_valid registered, 1 cycle delayed.
- X/unknown inputs are not gated; outputs follow the combinational function.
- Reset asserted mid-stream discards any in-flight result; no output pulses after reset assertion.
- in_valid and a/b sampled together; no backpressure (no ready signal), consumer must accept every out_valid beat.

Decomposition:
- Package half_adder_pkg:
  - localparam defaults DEFAULT_WIDTH=1 and DEFAULT_REGISTERED=1.
  - Typedef for the per-lane result struct {sum, cout}.
- Sub-module ha_cell:
  - Purely combinational one-bit half adder (a, b -> sum, cout).
  - Instantiated WIDTH times via generate.
- Top-level holds the output/valid registers and the REGISTERED select.

Test Plan:
- Reset: hold rst_n=0 with a=1, b=1, in_valid=1 -> sum=0, cout=0, out_valid=0 asynchronously, before any clk edge.
- Exhaustive, WIDTH=1, REGISTERED=1: drive {a,b}=0,1,2,3 on consecutive cycles with in_valid=1.
  - Expect one cycle later (sum,cout) = (0,0), (1,0), (1,0), (0,1).
  - out_valid stays 1 throughout.
- Hold: after {a,b}=11, drop in_valid and change to {a,b}=01 -> sum=0, cout=1 retained, out_valid=0 next cycle.
- Multi-lane, WIDTH=4: a=4'b1100, b=4'b1010 -> sum=4'b0110, cout=4'b1000 after 1 cycle; no inter-lane carry.
- Mid-stream reset: assert rst_n=0 in the cycle after presenting {a,b}=11 -> outputs clear at once, no cout=1 beat emerges.
- Combinational, REGISTERED=0: toggle {a,b} through all 4 values with 10 time-unit spacing -> sum/cout match the truth table within the same timestep; out_valid lags in_valid by 1 cycle.
